// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared I2S control types and slot/word width helpers
package ctrl_pkg;

  typedef enum logic [1:0] {STD_I2S = 2'd0, STD_MSB = 2'd1, STD_LSB = 2'd2} standard_t;
  typedef enum logic [1:0] {WORD_16 = 2'd0, WORD_24 = 2'd1, WORD_32 = 2'd2} word_size_t;
  typedef enum logic {FRAME_16 = 1'b0, FRAME_32 = 1'b1} frame_size_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_L = 2'd1, S_R = 2'd2, S_ERR = 2'd3} ws_state_t;

  localparam int SLOT_W = 32;

  function automatic logic [5:0] slot_bits(input frame_size_t f);
    return (f == FRAME_32) ? 6'd32 : 6'd16;
  endfunction

  function automatic logic [5:0] word_bits(input word_size_t w);
    case (w)
      WORD_16: return 6'd16;
      WORD_24: return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/i2s_slot_formatter.sv
// rtl/i2s_slot_formatter.sv - trims or aligns one PCM word into an F-bit channel slot
module i2s_slot_formatter
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  standard_t         standard,
  input  word_size_t        word_size,
  input  frame_size_t       frame_size,
  output logic [SLOT_W-1:0] slot
);

  logic [5:0]        w_bits;
  logic [5:0]        f_bits;
  logic [SLOT_W-1:0] w_mask;
  logic [SLOT_W-1:0] f_mask;
  logic [SLOT_W-1:0] w_clean;

  always_comb begin
    w_bits  = word_bits(word_size);
    f_bits  = slot_bits(frame_size);
    w_mask  = {SLOT_W{1'b1}} >> (6'd32 - w_bits);
    f_mask  = {SLOT_W{1'b1}} >> (6'd32 - f_bits);
    w_clean = SLOT_W'(word) & w_mask;
    // Slot occupies the F low bits; callers index it with F-relative positions
    if (w_bits > f_bits)
      slot = w_clean & f_mask;
    else if (standard == STD_LSB)
      slot = w_clean;
    else
      slot = w_clean << (f_bits - w_bits);
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - serializes stereo PCM pairs onto SD on SCK falling-edge strobes
module i2s_tx_serializer
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck_fall,
  input  logic              ws,
  input  standard_t         standard,
  input  word_size_t        word_size,
  input  frame_size_t       frame_size,
  input  logic              stereo,
  input  logic              mute,
  input  logic              stop,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sd,
  output logic              underrun,
  output logic              frame_err,
  output ws_state_t         state
);

  logic              ws_q;
  logic [5:0]        cnt;
  logic [SLOT_W-1:0] slot_l, slot_r;
  standard_t         cfg_std;
  word_size_t        cfg_word;
  frame_size_t       cfg_frame;
  logic              cfg_stereo;

  standard_t         eff_std;
  word_size_t        eff_word;
  frame_size_t       eff_frame;
  logic              eff_stereo;
  logic [SLOT_W-1:0] fmt_l, fmt_r, ld_l, ld_r;
  logic              boundary, frame_ok, left_start, tx_bit;
  logic [5:0]        cnt_nxt, f_bits;

  // I2S delays data by one SCK, so counter 0 carries the previous slot's LSB
  function automatic logic slot_bit(input logic [SLOT_W-1:0] slot, input logic prev_lsb,
                                    input standard_t std, input logic [5:0] f,
                                    input logic [5:0] k);
    if (std == STD_I2S)
      return (k == 6'd0) ? prev_lsb : slot[5'(f - k)];
    return slot[5'(f - 6'd1 - k)];
  endfunction

  // Config only follows the inputs while idle; it is frozen for the whole stream
  assign eff_std    = (state == S_IDLE) ? standard   : cfg_std;
  assign eff_word   = (state == S_IDLE) ? word_size  : cfg_word;
  assign eff_frame  = (state == S_IDLE) ? frame_size : cfg_frame;
  assign eff_stereo = (state == S_IDLE) ? stereo     : cfg_stereo;

  i2s_slot_formatter #(.DATA_W(DATA_W)) u_fmt_l (
    .word(in_left), .standard(eff_std), .word_size(eff_word),
    .frame_size(eff_frame), .slot(fmt_l)
  );

  i2s_slot_formatter #(.DATA_W(DATA_W)) u_fmt_r (
    .word(in_right), .standard(eff_std), .word_size(eff_word),
    .frame_size(eff_frame), .slot(fmt_r)
  );

  always_comb begin
    boundary   = (ws != ws_q);
    left_start = boundary && !ws;
    cnt_nxt    = boundary ? 6'd0 : cnt + 6'd1;
    f_bits     = slot_bits(eff_frame);
    frame_ok   = (boundary == (cnt == f_bits - 6'd1));
    ld_l       = in_valid ? fmt_l : '0;
    ld_r       = in_valid ? (eff_stereo ? fmt_r : fmt_l) : '0;
    tx_bit     = 1'b0;
    case (state)
      S_IDLE: tx_bit = slot_bit(ld_l, 1'b0, eff_std, f_bits, 6'd0);
      S_L:    tx_bit = boundary ? slot_bit(slot_r, slot_l[0], eff_std, f_bits, 6'd0)
                                : slot_bit(slot_l, 1'b0, eff_std, f_bits, cnt_nxt);
      S_R:    tx_bit = boundary ? slot_bit(ld_l, slot_r[0], eff_std, f_bits, 6'd0)
                                : slot_bit(slot_r, 1'b0, eff_std, f_bits, cnt_nxt);
      default: tx_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_q       <= 1'b1;
      cnt        <= '0;
      state      <= S_IDLE;
      sd         <= 1'b0;
      in_ready   <= 1'b0;
      underrun   <= 1'b0;
      frame_err  <= 1'b0;
      slot_l     <= '0;
      slot_r     <= '0;
      cfg_std    <= STD_I2S;
      cfg_word   <= WORD_16;
      cfg_frame  <= FRAME_16;
      cfg_stereo <= 1'b1;
    end else begin
      in_ready  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      if (sck_fall) begin
        ws_q <= ws;
        cnt  <= cnt_nxt;
        sd   <= 1'b0;
        if (stop) begin
          state <= S_IDLE;
        end else begin
          case (state)
            S_IDLE: if (left_start) begin
              state      <= S_L;
              cfg_std    <= standard;
              cfg_word   <= word_size;
              cfg_frame  <= frame_size;
              cfg_stereo <= stereo;
            end
            S_L, S_R: if (!frame_ok) begin
              state     <= S_ERR;
              frame_err <= 1'b1;
            end else if (boundary) begin
              state <= (state == S_L) ? S_R : S_L;
            end
            default: state <= S_IDLE;
          endcase
          if ((state == S_IDLE && left_start) || (state == S_L && frame_ok) ||
              (state == S_R && frame_ok))
            sd <= tx_bit & ~mute;
          if ((state == S_IDLE || state == S_R) && left_start &&
              (state == S_IDLE || frame_ok)) begin
            slot_l   <= ld_l;
            slot_r   <= ld_r;
            in_ready <= in_valid;
            underrun <= ~in_valid;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - directed self-checking bench for i2s_tx_serializer
module tb_i2s_tx_serializer;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck_fall = 1'b0;
  logic        ws = 1'b1;
  standard_t   standard = STD_I2S;
  word_size_t  word_size = WORD_16;
  frame_size_t frame_size = FRAME_16;
  logic        stereo = 1'b1, mute = 1'b0, stop = 1'b0;
  logic [31:0] in_left = '0, in_right = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, sd, underrun, frame_err;
  ws_state_t   state;

  int total = 0;
  int bad = 0;
  int n_ready, n_under, n_err;
  ws_state_t last_state, first_state;
  logic b;
  logic [31:0] lb, rb;

  i2s_tx_serializer #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .sck_fall(sck_fall), .ws(ws), .standard(standard),
    .word_size(word_size), .frame_size(frame_size), .stereo(stereo), .mute(mute),
    .stop(stop), .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
    .in_ready(in_ready), .sd(sd), .underrun(underrun), .frame_err(frame_err), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic w, output logic bit_o);
    ws = w;
    sck_fall = 1'b1;
    @(posedge clk); #1;
    bit_o = sd;
    n_ready += int'(in_ready);
    n_under += int'(underrun);
    n_err += int'(frame_err);
    last_state = state;
    sck_fall = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int f, output logic [31:0] l_o, output logic [31:0] r_o);
    logic bb;
    l_o = '0;
    r_o = '0;
    for (int k = 0; k < f; k++) begin
      strobe(1'b0, bb);
      if (k == 0) first_state = last_state;
      l_o = {l_o[30:0], bb};
    end
    for (int k = 0; k < f; k++) begin
      strobe(1'b1, bb);
      r_o = {r_o[30:0], bb};
    end
  endtask

  task automatic go_idle();
    logic bb;
    stop = 1'b1;
    strobe(1'b1, bb);
    stop = 1'b0;
    check("stop_to_idle", 32'(last_state), 32'(S_IDLE));
  endtask

  task automatic clr();
    n_ready = 0;
    n_under = 0;
    n_err = 0;
  endtask

  initial begin
    clr();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sd", 32'(sd), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_state", 32'(state), 32'(S_IDLE));
    rst = 1'b0;
    repeat (2) strobe(1'b1, b);
    check("idle_state", 32'(last_state), 32'(S_IDLE));

    // I2S, F=16, W=16: one-SCK delay, first bit after IDLE is 0
    standard = STD_I2S; word_size = WORD_16; frame_size = FRAME_16;
    in_left = 32'hA5A5; in_right = 32'h3C3C; in_valid = 1'b1;
    clr();
    send_frame(16, lb, rb);
    check("i2s_first_state", 32'(first_state), 32'(S_L));
    check("i2s_ready", n_ready, 1);
    check("i2s_left", lb, 32'h52D2);
    check("i2s_right", rb, 32'h9E1E);

    go_idle();
    standard = STD_MSB; word_size = WORD_24; frame_size = FRAME_32;
    in_left = 32'h123456; in_right = 32'hABCDEF;
    send_frame(32, lb, rb);
    check("msb24_left", lb, 32'h12345600);
    check("msb24_right", rb, 32'hABCDEF00);

    go_idle();
    standard = STD_LSB;
    send_frame(32, lb, rb);
    check("lsb24_left", lb, 32'h00123456);
    check("lsb24_right", rb, 32'h00ABCDEF);

    go_idle();
    standard = STD_MSB; word_size = WORD_32; frame_size = FRAME_16;
    in_left = 32'hDEADBEEF; in_right = 32'hCAFEF00D;
    send_frame(16, lb, rb);
    check("trim_left", lb, 32'hBEEF);
    check("trim_right", rb, 32'hF00D);

    go_idle();
    word_size = WORD_16; in_valid = 1'b0;
    clr();
    send_frame(16, lb, rb);
    check("under_pulse", n_under, 1);
    check("under_ready", n_ready, 0);
    check("under_left", lb, 32'h0);
    check("under_right", rb, 32'h0);
    in_left = 32'h1234; in_right = 32'h5678; in_valid = 1'b1;
    clr();
    send_frame(16, lb, rb);
    check("late_ready", n_ready, 1);
    check("late_under", n_under, 0);
    check("late_left", lb, 32'h1234);
    check("late_right", rb, 32'h5678);

    // WS toggles after 10 SCKs in a 16-bit slot
    clr();
    repeat (10) strobe(1'b0, b);
    strobe(1'b1, b);
    check("ferr_pulse", n_err, 1);
    check("ferr_state", 32'(last_state), 32'(S_ERR));
    check("ferr_sd", 32'(b), 32'd0);
    strobe(1'b1, b);
    check("ferr_idle", 32'(last_state), 32'(S_IDLE));
    check("ferr_sd_idle", 32'(b), 32'd0);
    in_left = 32'h0F0F; in_right = 32'hF0F0;
    clr();
    send_frame(16, lb, rb);
    check("resync_left", lb, 32'h0F0F);
    check("resync_right", rb, 32'hF0F0);
    check("resync_err", n_err, 0);

    mute = 1'b1; in_left = 32'hFFFF; in_right = 32'hFFFF;
    clr();
    send_frame(16, lb, rb);
    check("mute_left", lb, 32'h0);
    check("mute_right", rb, 32'h0);
    check("mute_ready", n_ready, 1);
    mute = 1'b0;

    go_idle();
    stereo = 1'b0; in_left = 32'h8001; in_right = 32'h1111;
    send_frame(16, lb, rb);
    check("mono_left", lb, 32'h8001);
    check("mono_right", rb, 32'h8001);

    stereo = 1'b1; in_left = 32'h7777;
    clr();
    repeat (5) strobe(1'b0, b);
    stop = 1'b1;
    strobe(1'b0, b);
    stop = 1'b0;
    check("stop_sd", 32'(b), 32'd0);
    check("stop_state", 32'(last_state), 32'(S_IDLE));
    repeat (3) strobe(1'b0, b);
    check("stop_stays_idle", 32'(last_state), 32'(S_IDLE));
    check("stop_sd_idle", 32'(b), 32'd0);
    strobe(1'b1, b);
    stop = 1'b1;
    strobe(1'b0, b);
    stop = 1'b0;
    check("stop_wins_state", 32'(last_state), 32'(S_IDLE));
    check("stop_ready", n_ready, 1);

    strobe(1'b1, b);
    repeat (4) strobe(1'b0, b);
    check("pre_rst_state", 32'(last_state), 32'(S_L));
    rst = 1'b1;
    #1;
    check("midrst_state", 32'(state), 32'(S_IDLE));
    check("midrst_sd", 32'(sd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Transmit-side data path of the I2S transceiver: takes stereo PCM sample pairs from the TX FIFO over a valid/ready handshake and serializes them onto SD.
- Timing comes from SCK falling-edge strobes and WS supplied by the clock/WS generator (master) or the pad synchronizer (slave). It is the counterpart of the receive deserializer.
- Supports Philips I2S, MSB-justified and LSB-justified formats, 16/32-bit channel slots, 16/24/32-bit words, mono, mute and stop.

Parameters:
- DATA_W, 32, width of each channel word port (max word size).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- sck_fall  in  1  one-clk strobe per SCK falling edge. All serial activity happens only on strobe cycles.
- ws  in  1  word select, already synchronous to clk; 0 = left, 1 = right.
- standard  in  standard_t  I2S/MSB/LSB format.
- word_size  in  word_size_t  PCM word width.
- frame_size  in  frame_size_t  slot bits per channel (F = 16 or 32).
- stereo, mute, stop  in  1 each  misc. options.
- in_left, in_right  in  DATA_W each  sample pair, right-aligned (word in LSBs).
- in_valid  in  1  sample pair available.
- in_ready  out  1  one-clk pulse: pair consumed.
- sd  out  1  serial data.
- underrun  out  1  one-clk pulse: no pair at frame start.
- frame_err  out  1  one-clk pulse: WS framing violation.
- state  out  ws_state_t  current channel state (debug).

Behaviour:
- Reset values: sd=0, in_ready=0, underrun=0, frame_err=0, state=IDLE, bit counter=0, ws_q=1, shift registers=0.
- All updates occur on clk cycles with sck_fall=1. sd changes on the clk edge ending the strobe cycle, i.e. 1 clk latency.
- ws_q holds ws from the previous strobe. A boundary is a strobe where ws != ws_q. The bit counter clears to 0 at a boundary and otherwise increments.
- Config (standard, word_size, frame_size, stereo) is latched on IDLE->L. Mid-frame changes are ignored until the next IDLE.
- State IDLE: sd=0. Go to L on a boundary with ws=0 (left start) when stop=0.
- State L: go to R on a boundary with ws=1. State R: go to L on a boundary with ws=0.
- Framing check: a boundary with counter != F-1, or counter reaching F without a boundary, triggers frame_err pulse -> ERR.
- State ERR: sd=0 for one strobe, then IDLE. Resync at the next left start.
- Load: at every left start (entry to L from IDLE or R), in_ready pulses iff in_valid=1, and left/right slots are latched.
  - If in_valid=0: underrun pulses and both slots are zero.
  - No consumption in IDLE or ERR.
- Slot formation (W = word bits, F = slot bits):
  - W > F: the word's MSBs are trimmed; the slot is the word's F LSBs.
  - W <= F, I2S or MSB format: word is left-aligned, LSBs zero-filled.
  - W <= F, LSB format: word is right-aligned, MSBs zero-filled.
- Bit ordering: MSB first.
  - MSB/LSB formats: slot bit F-1-k is driven at counter k.
  - I2S format: one SCK delay. Counter 0 drives bit 0 of the previous slot; counter k>=1 drives slot bit F-k. The first frame after IDLE drives 0 at counter 0.
- Mono (stereo=0): the right slot is a copy of the left slot.
- mute=1: sd forced 0; handshake and framing unaffected.
- stop=1: state goes to IDLE on the next strobe and sd=0. Any pending pair is not consumed.
- Simultaneous stop and left start: stop wins.
- rst mid-frame: immediate return to reset values. The partially sent pair is discarded.

Decomposition:
- Shared package: standard_t, word_size_t, frame_size_t and ws_state_t come from ctrl_pkg.
  - Add to ctrl_pkg: function slot_bits(frame_size_t) returning 16/32 and function word_bits(word_size_t) returning 16/24/32.
- Natural sub-module: i2s_slot_formatter, a combinational trim/align of one word into an F-bit slot. The receive side reuses its inverse.

Test Plan:
- I2S format, F=16, W=16, stereo, L=0xA5A5, R=0x3C3C valid -> in_ready pulses at left start. SD carries 0xA5A5 MSB-first starting one SCK after WS falls, then 0x3C3C one SCK after WS rises.
- MSB format, F=32, W=24, L=0x123456 -> SD = 0x12345600 with MSB aligned to the WS edge. LSB format, same input -> SD = 0x00123456 ending at the last SCK before WS toggles.
- F=16, W=32, L=0xDEADBEEF, MSB format -> SD = 0xBEEF (MSBs trimmed).
- in_valid=0 at left start -> underrun pulse, in_ready stays 0, SD all zero for the frame. Valid asserted mid-frame -> consumed at the next left start.
- WS toggles after 10 SCKs with F=16 -> frame_err pulse, state ERR then IDLE. Transmission resumes at the next WS 1->0 edge with the next pair.
- mute=1 with L=0xFFFF -> SD=0 and in_ready still pulses. stereo=0, L=0x8001 -> right slot transmits 0x8001. stop raised mid-left -> SD=0 from the next strobe, state IDLE, no in_ready.
